// File: rtl/sensor_frame_serializer_pkg.sv
// -----------------------------------------------------------------------------
// sensor_frame_serializer_pkg
//   Shared definitions for the sensor frame serializer:
//     - FSM state encoding (state_t)
//     - frame byte-region codes (region_t) and the index -> region classifier
//     - frame constants (default sync byte, fill byte, overrun saturation value)
//     - clog2 helper usable in localparam expressions
// -----------------------------------------------------------------------------
package sensor_frame_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_PULSE    = 3'd2,
      ST_WAIT_RDY = 3'd3,
      ST_START    = 3'd4,
      ST_DRAIN    = 3'd5
   } state_t;

   // Which part of the frame a byte index falls into.
   typedef enum logic [2:0] {
      RG_SYNC    = 3'd0,
      RG_SEQ     = 3'd1,
      RG_PAYLOAD = 3'd2,
      RG_CHK     = 3'd3,
      RG_NONE    = 3'd4
   } region_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h00;
   localparam logic [7:0] FILL_BYTE         = 8'hFF;  // byte presented for out-of-range indices
   localparam logic [7:0] OVERRUN_MAX       = 8'hFF;

   // Smallest r with 2**r >= n (0 for n <= 1).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Classify a byte index; regions appear in frame order sync, seq, payload, chk.
   function automatic region_t region_of(input int idx,
                                         input int sync_len,
                                         input int seq_len,
                                         input int payload_len,
                                         input int chk_len);
      if (idx < sync_len)                                return RG_SYNC;
      if (idx < sync_len + seq_len)                      return RG_SEQ;
      if (idx < sync_len + seq_len + payload_len)        return RG_PAYLOAD;
      if (idx < sync_len + seq_len + payload_len + chk_len) return RG_CHK;
      return RG_NONE;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   8N1 UART transmitter, LSB first, CLKS_PER_BIT clocks per bit.
//   Ports:
//     clk    in   system clock
//     start  in   accept data when ready=1 (one-cycle strobe)
//     rstn   in   async active-low reset; line forced idle (high)
//     data   in   byte to send, sampled with start
//     tx     out  serial line, idle high
//     ready  out  high when idle; drops on the edge that accepts start and
//                 rises again once the stop bit has been fully sent
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       start,
   input  logic       rstn,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic             active_q;
   logic [CNT_W-1:0] baud_q;
   logic [3:0]       bit_q;    // 0 = start bit, 1..8 = data bits, 9 = stop bit
   logic [8:0]       shift_q;  // {stop, data[7:1..]} remaining to shift out

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '1;
         tx       <= 1'b1;
      end else if (!active_q) begin
         if (start) begin
            active_q <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= {1'b1, data};
            tx       <= 1'b0;
         end
      end else if (baud_q == BAUD_LAST) begin
         baud_q <= '0;
         if (bit_q == 4'd9) begin
            active_q <= 1'b0;
         end else begin
            tx      <= shift_q[0];
            shift_q <= {1'b1, shift_q[8:1]};
            bit_q   <= bit_q + 4'd1;
         end
      end else begin
         baud_q <= baud_q + CNT_W'(1);
      end
   end

   assign ready = !active_q;

endmodule

// File: rtl/sensor_frame_serializer.sv
// -----------------------------------------------------------------------------
// sensor_frame_serializer
//   Captures one snapshot of N_SENSORS*N_ITER timestamps, pulses reset_parser,
//   then streams a frame over uart_tx:
//     SYNC_LEN x SYNC_BYTE, [seq], payload (words MSB byte first), [xor chk].
//   Requests that arrive while a frame is in flight are counted in a
//   saturating overrun counter.
//   Ports:
//     clk_12MHz          in   system clock
//     rstn               in   async active-low reset
//     data_availible     in   level: parser snapshot valid
//     sensor_iterations  in   N_SENSORS*N_ITER*TS_WIDTH; word 0 in the MSBs
//     tx                 out  UART line, idle high
//     reset_parser       out  one-cycle pulse after capture
//     busy               out  high whenever the FSM is not idle
//     overrun_count      out  saturating count of requests dropped while busy
// -----------------------------------------------------------------------------
module sensor_frame_serializer
   import sensor_frame_serializer_pkg::*;
#(
   parameter int         N_SENSORS    = 8,
   parameter int         N_ITER       = 2,
   parameter int         TS_WIDTH     = 17,
   parameter int         SYNC_LEN     = 3,
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
   parameter bit         SEQ_EN       = 1'b1,
   parameter bit         CHK_EN       = 1'b1,
   parameter int         CLKS_PER_BIT = 104
) (
   input  logic                                  clk_12MHz,
   input  logic                                  rstn,
   input  logic                                  data_availible,
   input  logic [N_SENSORS*N_ITER*TS_WIDTH-1:0]  sensor_iterations,
   output logic                                  tx,
   output logic                                  reset_parser,
   output logic                                  busy,
   output logic [7:0]                            overrun_count
);

   localparam int N_WORDS     = N_SENSORS * N_ITER;
   localparam int BPW         = (TS_WIDTH + 7) / 8;
   localparam int BUS_W       = N_WORDS * TS_WIDTH;
   localparam int SEQ_LEN     = SEQ_EN ? 1 : 0;
   localparam int CHK_LEN     = CHK_EN ? 1 : 0;
   localparam int PAYLOAD_LEN = N_WORDS * BPW;
   localparam int TOTAL       = SYNC_LEN + SEQ_LEN + PAYLOAD_LEN + CHK_LEN;
   localparam int IDX_W       = (clog2(TOTAL) < 1) ? 1 : clog2(TOTAL);
   localparam int MUX_DEPTH   = 1 << IDX_W;

   state_t           state_q, state_d;
   logic [BUS_W-1:0] shadow_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       chk_q;
   logic [7:0]       seq_q;
   logic [7:0]       tx_data_q;
   logic [7:0]       overrun_q;
   logic             holdoff_q;
   logic             da_q;
   logic             start;
   logic             ready;
   logic             uart_free;
   logic             last_byte;
   region_t          cur_region;
   logic [7:0]       frame_bytes [MUX_DEPTH];

   // uart_tx only drops ready on the edge after start, so ready is not
   // trusted during the cycle that follows a start strobe.
   assign uart_free  = ready && !holdoff_q;
   assign last_byte  = (int'(idx_q) == TOTAL - 1);
   assign cur_region = region_of(int'(idx_q), SYNC_LEN, SEQ_LEN, PAYLOAD_LEN, CHK_LEN);

   // ---------------------------------------------------------------- FSM ----
   always_ff @(posedge clk_12MHz or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every combinational output is given a default before the case so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (data_availible) state_d = ST_LOAD;
         ST_LOAD:     state_d = ST_PULSE;
         ST_PULSE:    state_d = ST_WAIT_RDY;
         ST_WAIT_RDY: if (uart_free) state_d = ST_START;
         ST_START:    state_d = last_byte ? ST_DRAIN : ST_WAIT_RDY;
         ST_DRAIN:    if (uart_free) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      reset_parser = 1'b0;
      busy         = 1'b1;
      start        = 1'b0;
      case (state_q)
         ST_IDLE:  busy         = 1'b0;
         ST_PULSE: reset_parser = 1'b1;
         ST_START: start        = 1'b1;
         default:  ;
      endcase
   end

   // ----------------------------------------------------------- capture ----
   // NOTE: the snapshot register carries no reset; it is always written in
   // LOAD before any byte of it is read, so reset logic would buy nothing.
   always_ff @(posedge clk_12MHz) begin
      if (state_q == ST_LOAD) shadow_q <= sensor_iterations;
   end

   // ---------------------------------------------------------- byte mux ----
   // Full frame laid out as a byte table indexed by idx_q; entries past the
   // frame end keep FILL_BYTE.
   always_comb begin
      logic [8*BPW-1:0] word_ext;
      word_ext = '0;
      for (int i = 0; i < MUX_DEPTH; i++) frame_bytes[i] = FILL_BYTE;
      for (int s = 0; s < SYNC_LEN; s++)  frame_bytes[s] = SYNC_BYTE;
      if (SEQ_LEN == 1) frame_bytes[SYNC_LEN] = seq_q;
      for (int w = 0; w < N_WORDS; w++) begin
         word_ext                 = '0;
         word_ext[TS_WIDTH-1:0]   = shadow_q[(N_WORDS-1-w)*TS_WIDTH +: TS_WIDTH];
         for (int b = 0; b < BPW; b++) begin
            frame_bytes[SYNC_LEN + SEQ_LEN + w*BPW + b] = word_ext[(BPW-1-b)*8 +: 8];
         end
      end
      if (CHK_LEN == 1) frame_bytes[TOTAL-1] = chk_q;
   end

   // ---------------------------------------------------------- datapath ----
   always_ff @(posedge clk_12MHz or negedge rstn) begin
      if (!rstn) begin
         idx_q     <= '0;
         chk_q     <= '0;
         seq_q     <= '0;
         tx_data_q <= FILL_BYTE;
         holdoff_q <= 1'b0;
      end else begin
         holdoff_q <= (state_q == ST_START);
         tx_data_q <= frame_bytes[idx_q];
         case (state_q)
            ST_LOAD: begin
               idx_q <= '0;
               chk_q <= '0;
            end
            ST_START: begin
               // tx_data_q is exactly the byte handed to the UART this cycle.
               if (cur_region == RG_SEQ || cur_region == RG_PAYLOAD)
                  chk_q <= chk_q ^ tx_data_q;
               if (!last_byte) idx_q <= idx_q + IDX_W'(1);
            end
            ST_DRAIN: begin
               if (uart_free) seq_q <= seq_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // ----------------------------------------------------------- overrun ----
   // A rising edge seen while not idle is a request the parser made that this
   // block could not serve; the DRAIN->IDLE cycle still counts as busy.
   always_ff @(posedge clk_12MHz or negedge rstn) begin
      if (!rstn) begin
         da_q      <= 1'b0;
         overrun_q <= '0;
      end else begin
         da_q <= data_availible;
         if (data_availible && !da_q && state_q != ST_IDLE && overrun_q != OVERRUN_MAX)
            overrun_q <= overrun_q + 8'd1;
      end
   end

   assign overrun_count = overrun_q;

   // -------------------------------------------------------------- UART ----
   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk   (clk_12MHz),
      .start (start),
      .rstn  (rstn),
      .data  (tx_data_q),
      .tx    (tx),
      .ready (ready)
   );

endmodule

// File: tb/tb_sensor_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_sensor_frame_serializer
//   Directed bench for sensor_frame_serializer. Three instances:
//     u_def   default frame geometry (53-byte frames)
//     u_wrap  one 17-bit word per frame (8-byte frames) for sequence wrap
//     u_small 4 x 24-bit words, no seq, no chk (15-byte frames)
//   A UART receiver per instance collects the bytes on each tx line.
// -----------------------------------------------------------------------------
module tb_sensor_frame_serializer;

   localparam int CPB_DEF   = 2;
   localparam int CPB_WRAP  = 1;
   localparam int CPB_SMALL = 2;

   logic clk = 1'b0;
   logic rstn;

   logic          da_d, da_w, da_s;
   logic [271:0]  bus_d;
   logic [16:0]   bus_w;
   logic [95:0]   bus_s;
   logic          tx_d, tx_w, tx_s;
   logic          rp_d, rp_w, rp_s;
   logic          busy_d, busy_w, busy_s;
   logic [7:0]    ov_d, ov_w, ov_s;

   logic [7:0] q_def[$];
   logic [7:0] q_wrap[$];
   logic [7:0] q_small[$];
   logic [7:0] got[$];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sensor_frame_serializer #(
      .CLKS_PER_BIT (CPB_DEF)
   ) u_def (
      .clk_12MHz (clk), .rstn (rstn), .data_availible (da_d),
      .sensor_iterations (bus_d), .tx (tx_d), .reset_parser (rp_d),
      .busy (busy_d), .overrun_count (ov_d)
   );

   sensor_frame_serializer #(
      .N_SENSORS (1), .N_ITER (1), .TS_WIDTH (17), .CLKS_PER_BIT (CPB_WRAP)
   ) u_wrap (
      .clk_12MHz (clk), .rstn (rstn), .data_availible (da_w),
      .sensor_iterations (bus_w), .tx (tx_w), .reset_parser (rp_w),
      .busy (busy_w), .overrun_count (ov_w)
   );

   sensor_frame_serializer #(
      .N_SENSORS (4), .N_ITER (1), .TS_WIDTH (24), .SEQ_EN (1'b0),
      .CHK_EN (1'b0), .CLKS_PER_BIT (CPB_SMALL)
   ) u_small (
      .clk_12MHz (clk), .rstn (rstn), .data_availible (da_s),
      .sensor_iterations (bus_s), .tx (tx_s), .reset_parser (rp_s),
      .busy (busy_s), .overrun_count (ov_s)
   );

   function automatic logic line_of(input int sel);
      case (sel)
         0:       return tx_d;
         1:       return tx_w;
         default: return tx_s;
      endcase
   endfunction

   function automatic logic busy_of(input int sel);
      case (sel)
         0:       return busy_d;
         1:       return busy_w;
         default: return busy_s;
      endcase
   endfunction

   function automatic logic [15:0] gb(input int i);
      return (i < got.size()) ? {8'h00, got[i]} : 16'hFFFF;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 8N1 receiver sampling at negedges: the start bit is seen in its first
   // cycle, so each later bit is exactly cpb negedges further on.
   task automatic rx_loop(input int sel, input int cpb);
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (line_of(sel) == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (cpb) @(negedge clk);
               b[i] = line_of(sel);
            end
            repeat (cpb) @(negedge clk);
            case (sel)
               0:       q_def.push_back(b);
               1:       q_wrap.push_back(b);
               default: q_small.push_back(b);
            endcase
         end
      end
   endtask

   initial rx_loop(0, CPB_DEF);
   initial rx_loop(1, CPB_WRAP);
   initial rx_loop(2, CPB_SMALL);

   task automatic wait_idle(input int sel, input int budget, input string tag);
      int n;
      n = 0;
      while (busy_of(sel) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, " idle"}, 16'(busy_of(sel)), 16'h0000);
      repeat (4) @(negedge clk);
   endtask

   // Raise data_availible and check the reset_parser pulse lands 2 cycles
   // later for exactly one cycle; the request is dropped after the pulse.
   task automatic start_def(input string tag);
      @(negedge clk) da_d = 1'b1;
      @(negedge clk) check({tag, " rp c1"}, 16'(rp_d), 16'h0000);
      @(negedge clk) check({tag, " rp c2"}, 16'(rp_d), 16'h0001);
      @(negedge clk) check({tag, " rp c3"}, 16'(rp_d), 16'h0000);
      da_d = 1'b0;
   endtask

   initial begin
      int low_seen;
      int n;
      int frames;
      logic [7:0] e;

      rstn  = 1'b0;
      da_d  = 1'b0;
      da_w  = 1'b0;
      da_s  = 1'b0;
      bus_d = '0;
      bus_w = '0;
      bus_s = '0;

      // ---- 1: reset state, and no start while held in reset
      repeat (3) @(negedge clk);
      check("t1 tx",      16'(tx_d),   16'h0001);
      check("t1 busy",    16'(busy_d), 16'h0000);
      check("t1 rp",      16'(rp_d),   16'h0000);
      check("t1 overrun", 16'(ov_d),   16'h0000);
      da_d = 1'b1;
      low_seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (!tx_d || !tx_w || !tx_s || busy_d) low_seen++;
      end
      check("t1 quiet in reset", 16'(low_seen), 16'h0000);
      da_d = 1'b0;
      @(negedge clk) rstn = 1'b1;
      repeat (5) @(negedge clk);
      check("t1 no bytes", 16'(q_def.size()), 16'h0000);

      // ---- 2: default frame, all words 17'h1ABCD
      for (int w = 0; w < 16; w++) bus_d[(15-w)*17 +: 17] = 17'h1ABCD;
      start_def("t2");
      wait_idle(0, 3000, "t2");
      got = q_def;
      q_def.delete();
      check("t2 size", 16'(got.size()), 16'd53);
      for (int i = 0; i < 53; i++) begin
         if (i < 4)        e = 8'h00;
         else if (i == 52) e = 8'h00;
         else case ((i - 4) % 3)
            0:       e = 8'h01;
            1:       e = 8'hAB;
            default: e = 8'hCD;
         endcase
         check($sformatf("t2 byte %0d", i), gb(i), {8'h00, e});
      end
      check("t2 overrun", 16'(ov_d), 16'h0000);

      // ---- 3: bus changes after capture, 3 overrun pulses, then saturation
      for (int w = 0; w < 16; w++) bus_d[(15-w)*17 +: 17] = 17'h1AA00 + 17'(w);
      start_def("t3");
      bus_d = '1;
      repeat (3) begin
         @(negedge clk) da_d = 1'b1;
         @(negedge clk) da_d = 1'b0;
      end
      @(negedge clk) check("t3 overrun 3", 16'(ov_d), 16'd3);
      wait_idle(0, 3000, "t3");
      got = q_def;
      q_def.delete();
      check("t3 size", 16'(got.size()), 16'd53);
      for (int i = 0; i < 53; i++) begin
         if (i < 3)        e = 8'h00;
         else if (i == 3)  e = 8'h01;
         else if (i == 52) e = 8'h01;
         else case ((i - 4) % 3)
            0:       e = 8'h01;
            1:       e = 8'hAA;
            default: e = 8'((i - 4) / 3);
         endcase
         check($sformatf("t3 byte %0d", i), gb(i), {8'h00, e});
      end

      for (int w = 0; w < 16; w++) bus_d[(15-w)*17 +: 17] = 17'h1ABCD;
      start_def("t3b");
      repeat (300) begin
         @(negedge clk) da_d = 1'b1;
         @(negedge clk) da_d = 1'b0;
      end
      @(negedge clk) check("t3b overrun sat", 16'(ov_d), 16'h00FF);
      wait_idle(0, 3000, "t3b");
      q_def.delete();

      // ---- 6: reset in the middle of byte 11, then a clean frame
      start_def("t6");
      n = 0;
      while (q_def.size() < 10 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t6 ten bytes", 16'(q_def.size() >= 10), 16'h0001);
      n = 0;
      while (tx_d && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6 mid byte", 16'(tx_d), 16'h0000);
      rstn = 1'b0;
      #1;
      check("t6 tx high",  16'(tx_d),   16'h0001);
      check("t6 busy low", 16'(busy_d), 16'h0000);
      check("t6 overrun",  16'(ov_d),   16'h0000);
      repeat (5) @(negedge clk);
      rstn = 1'b1;
      repeat (40) @(negedge clk);
      q_def.delete();
      start_def("t6b");
      wait_idle(0, 3000, "t6b");
      got = q_def;
      q_def.delete();
      check("t6b size", 16'(got.size()), 16'd53);
      for (int i = 0; i < 4; i++) check($sformatf("t6b byte %0d", i), gb(i), 16'h0000);
      check("t6b byte 4",   gb(4),  16'h0001);
      check("t6b chk",      gb(52), 16'h0000);

      // ---- 5: 4 x 24-bit words, no seq, no chk
      bus_s = {4{24'h123456}};
      @(negedge clk) da_s = 1'b1;
      n = 0;
      while (!rp_s && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5 rp", 16'(rp_s), 16'h0001);
      da_s = 1'b0;
      wait_idle(2, 2000, "t5");
      got = q_small;
      q_small.delete();
      check("t5 size", 16'(got.size()), 16'd15);
      for (int i = 0; i < 15; i++) begin
         if (i < 3) e = 8'h00;
         else case ((i - 3) % 3)
            0:       e = 8'h12;
            1:       e = 8'h34;
            default: e = 8'h56;
         endcase
         check($sformatf("t5 byte %0d", i), gb(i), {8'h00, e});
      end

      // ---- 4: 257 back-to-back frames, seq wraps, chk = seq ^ 01
      bus_w = 17'h00001;
      @(negedge clk) da_w = 1'b1;
      frames = 0;
      n = 0;
      while (frames < 257 && n < 40000) begin
         @(negedge clk);
         n++;
         if (rp_w) begin
            frames++;
            if (frames == 257) da_w = 1'b0;
         end
      end
      da_w = 1'b0;
      check("t4 frames", 16'(frames), 16'd257);
      wait_idle(1, 500, "t4");
      got = q_wrap;
      q_wrap.delete();
      check("t4 size", 16'(got.size()), 16'd2056);
      for (int f = 0; f < 257; f++) begin
         check($sformatf("t4 seq f%0d", f), gb(f*8 + 3), {8'h00, 8'(f)});
         check($sformatf("t4 chk f%0d", f), gb(f*8 + 7), {8'h00, 8'(f) ^ 8'h01});
      end
      check("t4 payload lsb", gb(6), 16'h0001);
      check("t4 overrun",     16'(ov_w), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
